serial_cfg_master: RTL and testbench



---
 rtl/serial_cfg_pkg.sv | 38 +++
 rtl/serial_cfg_arb.sv | 32 +++
 rtl/serial_cfg_master.sv | 225 ++++++++++++++++++++++
 tb/tb_serial_cfg_master.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cfg_pkg.sv
// -----------------------------------------------------------------------------
// serial_cfg_pkg
// Shared definitions for the 4-wire configuration bus master: frame geometry,
// write-flag value, counter widths, FSM state encoding, and a frame builder.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_cfg_pkg;

  localparam int FRAME_W   = 40;  // {write flag, addr[6:0], data[31:0]}
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 32;
  localparam int BIT_CNT_W = 6;   // holds FRAME_W
  localparam int PHASE_W   = 8;   // holds CLK_DIV-1 and GAP_CYCLES-1
  localparam int FCOUNT_W  = 16;

  localparam logic WR_FLAG = 1'b0;

  // Index of a requester port (two ports)
  typedef logic port_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_LOAD     = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  // Assemble the on-wire word, MSB transmitted first.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {WR_FLAG, addr, data};
  endfunction

endpackage

// File: rtl/serial_cfg_arb.sv
// -----------------------------------------------------------------------------
// serial_cfg_arb
// Two-port round-robin arbiter. Purely combinational; the caller owns the
// last_grant register and updates it when a grant is actually taken.
//
// Ports:
//   req_valid  in  2  request per port (bit 0 = port 0)
//   last_grant in  1  port granted most recently
//   grant      out 1  at least one request present
//   grant_idx  out 1  winning port (valid when grant = 1)
// -----------------------------------------------------------------------------
module serial_cfg_arb
  import serial_cfg_pkg::*;
(
  input  logic [1:0] req_valid,
  input  port_idx_t  last_grant,
  output logic       grant,
  output port_idx_t  grant_idx
);

  always_comb begin
    grant = |req_valid;
    if (&req_valid) begin
      // Tie: the port that won last time yields.
      grant_idx = ~last_grant;
    end else begin
      // Single requester (or none): port 1 only if it is the one asking.
      grant_idx = req_valid[1];
    end
  end

endmodule

// File: rtl/serial_cfg_master.sv
// -----------------------------------------------------------------------------
// serial_cfg_master
// Master for the 4-wire configuration bus (SEN, SCLK, SDI, SLD). Accepts
// register writes from two requesters (port 0: boot/init sequencer, port 1:
// USB host command path), arbitrates round-robin, and serialises each write
// as a 40-bit MSB-first frame {write flag, addr[6:0], data[31:0]} followed by
// a load strobe and an optional idle gap.
//
// Parameters:
//   CLK_DIV    clk cycles per SCLK half-period (1..255)
//   GAP_CYCLES idle clk cycles after SLD before the next grant (0..255)
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   req_valid    in   [1:0] write request per port
//   req_addr0/1  in   [6:0] register address per port
//   req_data0/1  in   [31:0] register data per port
//   req_ready    out  [1:0] one-cycle accept pulse; addr/data captured then
//   sen          out  frame enable, high for the whole shift
//   sclk         out  serial clock, slave samples on rising edge
//   sdi          out  serial data, MSB first, 0 outside frames
//   sld          out  load strobe
//   busy         out  high whenever the FSM is not idle
//   frame_count  out  [15:0] completed frames, wrapping
// -----------------------------------------------------------------------------
module serial_cfg_master
  import serial_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  input  logic [ADDR_W-1:0]   req_addr0,
  input  logic [DATA_W-1:0]   req_data0,
  input  logic [ADDR_W-1:0]   req_addr1,
  input  logic [DATA_W-1:0]   req_data1,
  output logic [1:0]          req_ready,
  output logic                sen,
  output logic                sclk,
  output logic                sdi,
  output logic                sld,
  output logic                busy,
  output logic [FCOUNT_W-1:0] frame_count
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("serial_cfg_master: CLK_DIV must be 1..255");
  end
  if (GAP_CYCLES > 255) begin : g_bad_gap
    $error("serial_cfg_master: GAP_CYCLES must be 0..255");
  end

  // Phase counters count down to zero, so they are loaded with length-1.
  localparam logic [PHASE_W-1:0] DIV_LOAD = PHASE_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : PHASE_W'(GAP_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BITS_LOAD = BIT_CNT_W'(FRAME_W);

  state_t                state_reg, state_next;
  logic [PHASE_W-1:0]    phase_reg, phase_next;
  logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [FRAME_W-1:0]    shift_reg, shift_next;
  port_idx_t             last_grant_reg, last_grant_next;
  logic [FCOUNT_W-1:0]   frame_count_reg;

  logic                  sen_reg, sen_next;
  logic                  sclk_reg, sclk_next;
  logic                  sdi_reg, sdi_next;
  logic                  sld_reg, sld_next;

  logic                  arb_grant;
  port_idx_t             arb_idx;
  logic [1:0]            grant_vec;
  logic                  phase_done;
  logic                  frame_done;

  serial_cfg_arb u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant_reg),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign phase_done = (phase_reg == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg - 1'b1;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    last_grant_next = last_grant_reg;
    grant_vec       = '0;
    frame_done      = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        phase_next = phase_reg;
        if (arb_grant) begin
          grant_vec[arb_idx] = 1'b1;
          shift_next = build_frame(arb_idx ? req_addr1 : req_addr0,
                                   arb_idx ? req_data1 : req_data0);
          last_grant_next = arb_idx;
          bit_cnt_next    = BITS_LOAD;
          phase_next      = DIV_LOAD;
          state_next      = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (phase_done) begin
          phase_next = DIV_LOAD;
          state_next = ST_SHIFT_HI;
        end
      end

      ST_SHIFT_HI: begin
        if (phase_done) begin
          // The next bit moves onto sdi together with the SCLK falling edge,
          // so sdi is stable around every rising edge.
          shift_next   = {shift_reg[FRAME_W-2:0], 1'b0};
          bit_cnt_next = bit_cnt_reg - 1'b1;
          phase_next   = DIV_LOAD;
          state_next   = ST_SHIFT_LO;
        end
      end

      ST_SHIFT_LO: begin
        if (phase_done) begin
          phase_next = DIV_LOAD;
          state_next = (bit_cnt_reg == '0) ? ST_LOAD : ST_SHIFT_HI;
        end
      end

      ST_LOAD: begin
        if (phase_done) begin
          frame_done = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_next = ST_IDLE;
          end else begin
            phase_next = GAP_LOAD;
            state_next = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (phase_done) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the next state and registered so the pins
  // are glitch-free and line up exactly with the state they belong to.
  always_comb begin
    sen_next  = (state_next == ST_SETUP) || (state_next == ST_SHIFT_HI) ||
                (state_next == ST_SHIFT_LO);
    sclk_next = (state_next == ST_SHIFT_HI);
    sdi_next  = sen_next & shift_next[FRAME_W-1];
    sld_next  = (state_next == ST_LOAD);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      phase_reg       <= '0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      last_grant_reg  <= 1'b1;  // port 0 wins the first contention
      sen_reg         <= 1'b0;
      sclk_reg        <= 1'b0;
      sdi_reg         <= 1'b0;
      sld_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      last_grant_reg  <= last_grant_next;
      sen_reg         <= sen_next;
      sclk_reg        <= sclk_next;
      sdi_reg         <= sdi_next;
      sld_reg         <= sld_next;
    end
  end

  // Frame counter only moves on a completed load; an aborted frame never
  // reaches LOAD, so it is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_reg <= '0;
    end else if (frame_done) begin
      frame_count_reg <= frame_count_reg + 1'b1;
    end
  end

  // The accept pulse is combinational from the arbiter so the requester's
  // addr/data are captured in the very cycle it sees ready; it is held low
  // while reset is asserted.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = grant_vec[gi] & reset_n;
  end

  assign sen         = sen_reg;
  assign sclk        = sclk_reg;
  assign sdi         = sdi_reg;
  assign sld         = sld_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_serial_cfg_master.sv
`timescale 1ns/1ps
module tb_serial_cfg_master;
  import serial_cfg_pkg::*;

  localparam int NI = 2;  // instance 0: defaults, instance 1: CLK_DIV=1, GAP=0

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction
  function automatic int gap_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid [NI];
  logic [6:0]  req_addr0 [NI];
  logic [31:0] req_data0 [NI];
  logic [6:0]  req_addr1 [NI];
  logic [31:0] req_data1 [NI];
  logic [1:0]  req_ready [NI];
  logic        sen [NI];
  logic        sclk [NI];
  logic        sdi [NI];
  logic        sld [NI];
  logic        busy [NI];
  logic [15:0] frame_count [NI];

  serial_cfg_master #(.CLK_DIV(2), .GAP_CYCLES(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]),
    .req_addr0(req_addr0[0]), .req_data0(req_data0[0]),
    .req_addr1(req_addr1[0]), .req_data1(req_data1[0]),
    .req_ready(req_ready[0]), .sen(sen[0]), .sclk(sclk[0]), .sdi(sdi[0]),
    .sld(sld[0]), .busy(busy[0]), .frame_count(frame_count[0])
  );

  serial_cfg_master #(.CLK_DIV(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]),
    .req_addr0(req_addr0[1]), .req_data0(req_data0[1]),
    .req_addr1(req_addr1[1]), .req_data1(req_data1[1]),
    .req_ready(req_ready[1]), .sen(sen[1]), .sclk(sclk[1]), .sdi(sdi[1]),
    .sld(sld[1]), .busy(busy[1]), .frame_count(frame_count[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard entries: pushed by stimulus, popped by the monitor.
  typedef struct {
    int          inst;
    int          port;
    logic [39:0] word;
    bit          b2b;   // granted in the first idle cycle after the previous frame
  } exp_t;

  exp_t grant_q[$];
  exp_t frame_q[$];
  int   model_last [NI];   // reference model of the round-robin pointer

  // ---------------------------------------------------------------------------
  // Monitor: decodes the bus of each instance and compares with the queues
  // ---------------------------------------------------------------------------
  logic [39:0] cap [NI];
  int          nbits [NI];
  int          busy_run [NI];
  int          sen_run [NI];
  int          sld_run [NI];
  logic        p_sen [NI], p_sclk [NI], p_sdi [NI], p_sld [NI], p_busy [NI];
  logic [15:0] exp_fc [NI];
  longint      cyc = 0;
  longint      last_gcyc [NI];
  exp_t        mon_e;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        cap[i] = '0; nbits[i] = 0; busy_run[i] = 0; sen_run[i] = 0;
        sld_run[i] = 0; exp_fc[i] = '0; last_gcyc[i] = 0;
        p_sen[i] = 0; p_sclk[i] = 0; p_sdi[i] = 0; p_sld[i] = 0; p_busy[i] = 0;
      end else begin
        if (!busy[i] && req_valid[i] != 2'b00)
          check("idle_grant", {63'd0, req_ready[i] != 2'b00}, 64'd1);
        if (req_ready[i] != 2'b00) begin
          check("ready_onehot", $countones(req_ready[i]), 1);
          check("grant_expected", {63'd0, grant_q.size() > 0}, 64'd1);
          if (grant_q.size() > 0) begin
            mon_e = grant_q.pop_front();
            check("grant_inst", i, mon_e.inst);
            check("grant_port", {63'd0, req_ready[i][1]}, mon_e.port);
            if (mon_e.b2b)
              check("grant_spacing", cyc - last_gcyc[i],
                    1 + 82 * div_of(i) + gap_of(i));
          end
          last_gcyc[i] = cyc;
        end
        if (sdi[i] !== p_sdi[i]) check("sdi_change_sclk_low", sclk[i], 0);
        if (!sen[i]) check("sdi_idle", sdi[i], 0);
        if (sen[i] && !p_sen[i]) begin
          nbits[i] = 0; cap[i] = '0; sen_run[i] = 0;
        end
        if (sen[i]) sen_run[i]++;
        if (!sen[i] && p_sen[i]) check("sen_width", sen_run[i], 81 * div_of(i));
        if (sclk[i] && !p_sclk[i]) begin
          check("sclk_in_frame", sen[i], 1);
          cap[i] = {cap[i][38:0], sdi[i]};
          nbits[i]++;
        end
        if (sld[i]) begin
          sld_run[i]++;
          check("sld_sen_excl", sen[i], 0);
        end
        if (!sld[i] && p_sld[i]) begin
          check("sld_width", sld_run[i], div_of(i));
          check("frame_bits", nbits[i], 40);
          check("frame_expected", {63'd0, frame_q.size() > 0}, 64'd1);
          if (frame_q.size() > 0) begin
            mon_e = frame_q.pop_front();
            check("frame_inst", i, mon_e.inst);
            check("frame_word", cap[i], mon_e.word);
            $display("frame inst=%0d port=%0d word=%010h", i, mon_e.port, cap[i]);
          end
          exp_fc[i] = exp_fc[i] + 16'd1;
          sld_run[i] = 0;
        end
        if (busy[i]) busy_run[i]++;
        if (!busy[i] && p_busy[i]) begin
          check("busy_len", busy_run[i], 82 * div_of(i) + gap_of(i));
          check("frame_count", frame_count[i], exp_fc[i]);
          busy_run[i] = 0;
        end
        p_sen[i] = sen[i]; p_sclk[i] = sclk[i]; p_sdi[i] = sdi[i];
        p_sld[i] = sld[i]; p_busy[i] = busy[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input int i);
    int budget = 0;
    @(negedge clk);
    while (busy[i] && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check("idle_timeout", busy[i], 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Push the model's expected grant order, then present the requests and
  // retire each one on its accept pulse.
  task automatic issue(input int i, input logic [1:0] mask,
                       input logic [6:0] a0, input logic [31:0] d0,
                       input logic [6:0] a1, input logic [31:0] d1);
    int   order[$];
    int   first;
    exp_t e;
    if (mask == 2'b11) begin
      first = (model_last[i] == 0) ? 1 : 0;
      order.push_back(first);
      order.push_back(1 - first);
    end else begin
      order.push_back(mask[1] ? 1 : 0);
    end
    for (int k = 0; k < order.size(); k++) begin
      e.inst = i;
      e.port = order[k];
      e.word = {1'b0, (order[k] == 1) ? a1 : a0, (order[k] == 1) ? d1 : d0};
      e.b2b  = (k == 1);
      grant_q.push_back(e);
      frame_q.push_back(e);
    end
    model_last[i] = order[order.size() - 1];
    @(posedge clk); #1;
    req_addr0[i] = a0; req_data0[i] = d0;
    req_addr1[i] = a1; req_data1[i] = d1;
    req_valid[i] = mask;
  endtask

  task automatic retire(input int i);
    int         budget = 0;
    logic [1:0] g;
    while (req_valid[i] != 2'b00 && budget < 1000) begin
      @(negedge clk);
      budget++;
      g = req_ready[i];
      if (g != 2'b00) begin
        @(posedge clk); #1;
        req_valid[i] = req_valid[i] & ~g;
        // Requester is free to move on once accepted.
        if (g[0]) begin req_addr0[i] = 7'($urandom); req_data0[i] = $urandom; end
        if (g[1]) begin req_addr1[i] = 7'($urandom); req_data1[i] = $urandom; end
      end
    end
    check("grant_timeout", req_valid[i], 0);
    req_valid[i] = 2'b00;
  endtask

  task automatic run_round(input int i, input logic [1:0] mask,
                           input logic [6:0] a0, input logic [31:0] d0,
                           input logic [6:0] a1, input logic [31:0] d1);
    issue(i, mask, a0, d0, a1, d1);
    retire(i);
    wait_idle(i);
  endtask

  task automatic random_round(input int i);
    run_round(i, 2'($urandom_range(1, 3)), 7'($urandom), $urandom,
              7'($urandom), $urandom);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int rises;
    int budget;
    logic prv;

    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 2'b00; req_addr0[i] = '0; req_data0[i] = '0;
      req_addr1[i] = '0; req_data1[i] = '0; model_last[i] = 1;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_sen", sen[i], 0);
      check("rst_sclk", sclk[i], 0);
      check("rst_sdi", sdi[i], 0);
      check("rst_sld", sld[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_ready", req_ready[i], 0);
      check("rst_frame_count", frame_count[i], 0);
    end
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    // Contention: port 0 first after reset, then alternation 0,1,0,1.
    run_round(0, 2'b11, 7'h01, 32'hAAAA5555, 7'h02, 32'h0000FFFF);
    run_round(0, 2'b11, 7'($urandom), $urandom, 7'($urandom), $urandom);
    // Single write from port 1.
    run_round(0, 2'b10, 7'h00, 32'h0, 7'h05, 32'h01234567);
    for (int r = 0; r < 12; r++) random_round(0);

    // Reset mid-frame at bit 20, with a port 0 request pending across reset.
    issue(0, 2'b10, 7'h00, 32'h0, 7'h33, 32'hDEADBEEF);
    retire(0);
    rises = 0; budget = 0; prv = sclk[0];
    while (rises < 20 && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (sclk[0] && !prv) rises++;
      prv = sclk[0];
    end
    check("abort_reach_bit20", rises, 20);
    req_addr0[0] = 7'h11; req_data0[0] = 32'h600DF00D; req_valid[0] = 2'b01;
    #2 reset_n = 1'b0;
    #1;
    check("abort_sen", sen[0], 0);
    check("abort_sclk", sclk[0], 0);
    check("abort_sdi", sdi[0], 0);
    check("abort_sld", sld[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_ready", req_ready[0], 0);
    check("abort_frame_count", frame_count[0], 0);
    check("abort_no_frame", frame_q.size(), 1);
    check("abort_no_grant", grant_q.size(), 0);
    frame_q.delete();
    grant_q.delete();
    for (int i = 0; i < NI; i++) model_last[i] = 1;
    grant_q.push_back('{inst: 0, port: 0, word: {1'b0, 7'h11, 32'h600DF00D}, b2b: 1'b0});
    frame_q.push_back('{inst: 0, port: 0, word: {1'b0, 7'h11, 32'h600DF00D}, b2b: 1'b0});
    model_last[0] = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b1;
    retire(0);
    wait_idle(0);
    check("post_abort_count", frame_count[0], 1);

    // Wrap of the frame counter.
    force dut0.frame_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut0.frame_count_reg;
    exp_fc[0] = 16'hFFFF;
    @(negedge clk);
    check("wrap_preload", frame_count[0], 16'hFFFF);
    random_round(0);
    check("wrap_zero", frame_count[0], 0);

    // Fast instance: CLK_DIV=1, GAP_CYCLES=0.
    run_round(1, 2'b11, 7'h7F, 32'hFFFFFFFF, 7'h40, 32'h80000001);
    run_round(1, 2'b11, 7'($urandom), $urandom, 7'($urandom), $urandom);
    for (int r = 0; r < 6; r++) random_round(1);

    check("grant_q_empty", grant_q.size(), 0);
    check("frame_q_empty", frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
